// File: rtl/wb_intercon_n.sv
// Single-master to N-slave Wishbone interconnect with address-field slave decode and one-cycle ack/err.
// Optional ack timeout enabled by defining WB_INTERCON_TIMEOUT_EN.
module wb_intercon_n #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_LSB    = 16,
    parameter int TIMEOUT    = 255,
    localparam int SW        = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [ADDR_WIDTH-1:0]            m_adr_i,
    input  logic [DATA_WIDTH-1:0]            m_dat_i,
    input  logic                             m_we_i,
    input  logic                             m_stb_i,
    input  logic                             m_cyc_i,
    input  logic                             m_tagn_i,
    output logic [DATA_WIDTH-1:0]            m_dat_o,
    output logic                             m_ack_o,
    output logic                             m_err_o,
    output logic                             m_tagn_o,
    output logic [ADDR_WIDTH-1:0]            s_adr_o,
    output logic [DATA_WIDTH-1:0]            s_dat_o,
    output logic                             s_we_o,
    output logic                             s_tagn_o,
    output logic [NUM_SLAVES-1:0]            s_cyc_o,
    output logic [NUM_SLAVES-1:0]            s_stb_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_dat_i,
    input  logic [NUM_SLAVES-1:0]            s_ack_i,
    input  logic [NUM_SLAVES-1:0]            s_tagn_i,
    output logic                             busy_o,
    output logic [SW-1:0]                    sel_o
);

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : g_bad_num_slaves
        $error("wb_intercon_n: NUM_SLAVES must be 1..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("wb_intercon_n: TIMEOUT must be >= 1");
    end
    if (SEL_LSB + SW > ADDR_WIDTH) begin : g_bad_sel_field
        $error("wb_intercon_n: slave-select field exceeds address width");
    end

    localparam logic [SW:0] NUM_S = (SW+1)'(NUM_SLAVES);

    typedef enum logic [2:0] {IDLE, ACTIVE, RESP, ERR, RELEASE} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SW-1:0]           req_idx;
    logic                    req_mapped;
    logic [NUM_SLAVES-1:0]   req_onehot;
    logic [NUM_SLAVES-1:0]   strobe;
    logic                    sel_ack;
    logic                    sel_tagn;
    logic [DATA_WIDTH-1:0]   sel_dat;
    logic                    timed_out;

    assign req_idx    = m_adr_i[SEL_LSB +: SW];
    assign req_mapped = {1'b0, req_idx} < NUM_S;

    // Decode the incoming request and mux back the currently selected slave's response.
    always_comb begin
        req_onehot = '0;
        sel_ack    = 1'b0;
        sel_dat    = '0;
        sel_tagn   = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            req_onehot[i] = (req_idx == SW'(i));
            if (sel_o == SW'(i)) begin
                sel_ack  = s_ack_i[i];
                sel_dat  = s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tagn = s_tagn_i[i];
            end
        end
    end

`ifdef WB_INTERCON_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt;

    // The cycle whose increment would reach TIMEOUT is the last one a slave gets to ack.
    assign timed_out = (to_cnt + CW'(1)) == CW'(TIMEOUT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (state == IDLE && state_next == ACTIVE) begin
            to_cnt <= '0;
        end else if (state == ACTIVE && !sel_ack) begin
            to_cnt <= to_cnt + CW'(1);
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort beats ack, and ack beats timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    state_next = req_mapped ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                if (!m_cyc_i) begin
                    state_next = IDLE;
                end else if (sel_ack) begin
                    state_next = RESP;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            RESP:    state_next = RELEASE;
            ERR:     state_next = RELEASE;
            RELEASE: begin
                if (!m_stb_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            strobe   <= '0;
            sel_o    <= '0;
            s_adr_o  <= '0;
            s_dat_o  <= '0;
            s_we_o   <= 1'b0;
            s_tagn_o <= 1'b1;
            m_dat_o  <= '0;
            m_tagn_o <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m_cyc_i && m_stb_i) begin
                        s_adr_o  <= m_adr_i;
                        s_dat_o  <= m_dat_i;
                        s_we_o   <= m_we_i;
                        s_tagn_o <= m_tagn_i;
                        sel_o    <= req_idx;
                        if (req_mapped) begin
                            strobe <= req_onehot;
                        end else begin
                            m_dat_o <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (state_next != ACTIVE) begin
                        strobe <= '0;
                    end
                    if (state_next == RESP) begin
                        m_dat_o  <= sel_dat;
                        m_tagn_o <= sel_tagn;
                    end else if (state_next == ERR) begin
                        m_dat_o <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_cyc_o = strobe;
    assign s_stb_o = strobe;
    assign m_ack_o = (state == RESP);
    assign m_err_o = (state == ERR);
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_wb_intercon_n.sv
// Randomized transaction-level bench for wb_intercon_n (3 slaves, so one select code is unmapped).
// Build with WB_INTERCON_TIMEOUT_EN defined to also exercise the ack timeout.
module tb_wb_intercon_n;

    localparam int NS = 3;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SL = 16;
    localparam int TO = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     m_adr_i;
    logic [DW-1:0]     m_dat_i;
    logic              m_we_i;
    logic              m_stb_i;
    logic              m_cyc_i;
    logic              m_tagn_i;
    logic [DW-1:0]     m_dat_o;
    logic              m_ack_o;
    logic              m_err_o;
    logic              m_tagn_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic              s_we_o;
    logic              s_tagn_o;
    logic [NS-1:0]     s_cyc_o;
    logic [NS-1:0]     s_stb_o;
    logic [NS*DW-1:0]  s_dat_i;
    logic [NS-1:0]     s_ack_i;
    logic [NS-1:0]     s_tagn_i;
    logic              busy_o;
    logic [1:0]        sel_o;

    int checks = 0;
    int errors = 0;
    int to_limit;
    int max_delay;

    wb_intercon_n #(
        .NUM_SLAVES(NS),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SEL_LSB(SL),
        .TIMEOUT(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i),
        .m_we_i(m_we_i),
        .m_stb_i(m_stb_i),
        .m_cyc_i(m_cyc_i),
        .m_tagn_i(m_tagn_i),
        .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .m_tagn_o(m_tagn_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_we_o(s_we_o),
        .s_tagn_o(s_tagn_o),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i),
        .s_tagn_i(s_tagn_i),
        .busy_o(busy_o),
        .sel_o(sel_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Master holds the strobe in RELEASE for 'hold' extra cycles, then drops it and the bus goes idle.
    task automatic finishRelease(input int hold);
        repeat (hold) begin
            @(posedge clk_i); #1;
            checkOutput("release_busy", busy_o, 1);
            checkOutput("release_stb", s_stb_o, 0);
            checkOutput("release_ack", m_ack_o, 0);
            checkOutput("release_err", m_err_o, 0);
        end
        @(negedge clk_i);
        m_stb_i = 1'b0;
        m_cyc_i = 1'($urandom);
        @(posedge clk_i); #1;
        checkOutput("release_idle", busy_o, 0);
    endtask

    // One master transaction; the bench plays all slaves and predicts every visible output.
    task automatic applyStimulus(input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic we,
                                 input logic tagn, input int ack_delay, input logic [DW-1:0] sdat,
                                 input logic stag, input int abort_at, input int reset_at, input int hold);
        int            field;
        logic [NS-1:0] oh;
        logic [NS-1:0] one;
        bit            done;
        field = int'(adr[SL +: 2]);
        one   = 1;
        oh    = (field < NS) ? (one << field) : '0;

        @(negedge clk_i);
        m_adr_i  = adr;
        m_dat_i  = dat;
        m_we_i   = we;
        m_tagn_i = tagn;
        m_cyc_i  = 1'b1;
        m_stb_i  = 1'b1;
        s_ack_i  = '0;
        @(posedge clk_i); #1;
        checkOutput("req_busy", busy_o, 1);
        checkOutput("req_sel", sel_o, field[1:0]);
        checkOutput("req_s_adr", s_adr_o, adr);
        checkOutput("req_s_dat", s_dat_o, dat);
        checkOutput("req_s_we", s_we_o, we);
        checkOutput("req_s_tagn", s_tagn_o, tagn);
        checkOutput("req_ack", m_ack_o, 0);

        if (field >= NS) begin
            checkOutput("unmapped_stb", s_stb_o, 0);
            checkOutput("unmapped_cyc", s_cyc_o, 0);
            checkOutput("unmapped_err", m_err_o, 1);
            checkOutput("unmapped_dat", m_dat_o, 0);
            @(posedge clk_i); #1;
            checkOutput("unmapped_err_len", m_err_o, 0);
            checkOutput("unmapped_busy", busy_o, 1);
            finishRelease(hold);
            return;
        end

        checkOutput("req_stb", s_stb_o, oh);
        checkOutput("req_cyc", s_cyc_o, oh);
        checkOutput("req_err", m_err_o, 0);

        done = 1'b0;
        for (int n = 1; !done && n <= 64; n++) begin
            @(negedge clk_i);
            for (int i = 0; i < NS; i++) begin
                s_dat_i[i*DW +: DW] = $urandom;
                s_tagn_i[i]         = 1'($urandom);
                s_ack_i[i]          = ($urandom % 3) == 0;
            end
            s_ack_i[field]           = (n == ack_delay + 1);
            s_dat_i[field*DW +: DW]  = sdat;
            s_tagn_i[field]          = stag;
            if (n == abort_at) begin
                m_cyc_i = 1'b0;
                m_stb_i = 1'b0;
            end
            if (n == reset_at) rst_i = 1'b1;
            @(posedge clk_i); #1;

            if (n == reset_at) begin
                checkOutput("rst_stb", s_stb_o, 0);
                checkOutput("rst_cyc", s_cyc_o, 0);
                checkOutput("rst_ack", m_ack_o, 0);
                checkOutput("rst_err", m_err_o, 0);
                checkOutput("rst_busy", busy_o, 0);
                checkOutput("rst_sel", sel_o, 0);
                checkOutput("rst_s_adr", s_adr_o, 0);
                checkOutput("rst_s_dat", s_dat_o, 0);
                checkOutput("rst_s_we", s_we_o, 0);
                checkOutput("rst_m_dat", m_dat_o, 0);
                checkOutput("rst_m_tagn", m_tagn_o, 1);
                checkOutput("rst_s_tagn", s_tagn_o, 1);
                @(negedge clk_i);
                rst_i   = 1'b0;
                s_ack_i = '0;
                m_cyc_i = 1'b0;
                m_stb_i = 1'b0;
                done    = 1'b1;
            end else if (n == abort_at) begin
                checkOutput("abort_stb", s_stb_o, 0);
                checkOutput("abort_cyc", s_cyc_o, 0);
                checkOutput("abort_ack", m_ack_o, 0);
                checkOutput("abort_err", m_err_o, 0);
                checkOutput("abort_busy", busy_o, 0);
                done = 1'b1;
            end else if (n == ack_delay + 1) begin
                checkOutput("ack_stb", s_stb_o, 0);
                checkOutput("ack_m_ack", m_ack_o, 1);
                checkOutput("ack_m_err", m_err_o, 0);
                checkOutput("ack_m_dat", m_dat_o, sdat);
                checkOutput("ack_m_tagn", m_tagn_o, stag);
                @(negedge clk_i);
                s_ack_i = '0;
                @(posedge clk_i); #1;
                checkOutput("ack_len", m_ack_o, 0);
                checkOutput("ack_release_busy", busy_o, 1);
                finishRelease(hold);
                done = 1'b1;
            end else if (n == to_limit) begin
                checkOutput("timeout_stb", s_stb_o, 0);
                checkOutput("timeout_err", m_err_o, 1);
                checkOutput("timeout_ack", m_ack_o, 0);
                checkOutput("timeout_dat", m_dat_o, 0);
                @(negedge clk_i);
                s_ack_i = '0;
                @(posedge clk_i); #1;
                checkOutput("timeout_err_len", m_err_o, 0);
                checkOutput("timeout_busy", busy_o, 1);
                finishRelease(hold);
                done = 1'b1;
            end else begin
                checkOutput("wait_stb", s_stb_o, oh);
                checkOutput("wait_ack", m_ack_o, 0);
                checkOutput("wait_err", m_err_o, 0);
                checkOutput("wait_busy", busy_o, 1);
            end
        end
    endtask

    initial begin
        int ad;
        int lim;
        int ab;
        int rs;
`ifdef WB_INTERCON_TIMEOUT_EN
        to_limit  = TO;
        max_delay = 11;
`else
        to_limit  = 1000;
        max_delay = 6;
`endif
        rst_i    = 1'b1;
        m_adr_i  = '0;
        m_dat_i  = '0;
        m_we_i   = 1'b0;
        m_stb_i  = 1'b0;
        m_cyc_i  = 1'b0;
        m_tagn_i = 1'b1;
        s_dat_i  = '0;
        s_ack_i  = '0;
        s_tagn_i = '1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_stb", s_stb_o, 0);
        checkOutput("reset_cyc", s_cyc_o, 0);
        checkOutput("reset_ack", m_ack_o, 0);
        checkOutput("reset_err", m_err_o, 0);
        checkOutput("reset_sel", sel_o, 0);
        checkOutput("reset_m_dat", m_dat_o, 0);
        checkOutput("reset_s_adr", s_adr_o, 0);
        checkOutput("reset_s_we", s_we_o, 0);
        checkOutput("reset_m_tagn", m_tagn_o, 1);
        checkOutput("reset_s_tagn", s_tagn_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("[TB] directed transactions");
        applyStimulus(26'h0020010, 32'h1234_5678, 1'b0, 1'b1, 0, 32'hA5A5_0001, 1'b0, 0, 0, 0);
        applyStimulus(26'h0010001, 32'h0000_00C3, 1'b1, 1'b0, 3, 32'h0BAD_F00D, 1'b1, 0, 0, 1);
        applyStimulus(26'h0030000, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 32'h1111_1111, 1'b0, 0, 0, 0);
        applyStimulus(26'h0000040, 32'h0000_0001, 1'b1, 1'b1, 1, 32'h2222_2222, 1'b0, 2, 0, 0);
        applyStimulus(26'h0020000, 32'h0000_0002, 1'b0, 1'b0, 4, 32'h3333_3333, 1'b1, 0, 2, 0);
`ifdef WB_INTERCON_TIMEOUT_EN
        applyStimulus(26'h0000004, 32'h0000_0003, 1'b0, 1'b1, TO - 1, 32'h4444_4444, 1'b0, 0, 0, 0);
        applyStimulus(26'h0010008, 32'h0000_0004, 1'b0, 1'b1, 30, 32'h5555_5555, 1'b0, 0, 0, 1);
`endif

        $display("[TB] random transactions");
        for (int t = 0; t < 150; t++) begin
            ad  = $urandom_range(0, max_delay);
            lim = ad + 1;
            if (lim > to_limit) lim = to_limit;
            ab  = (($urandom % 6) == 0) ? $urandom_range(1, lim) : 0;
            rs  = (($urandom % 10) == 0) ? $urandom_range(1, lim) : 0;
            applyStimulus(AW'($urandom), $urandom, 1'($urandom), 1'($urandom), ad,
                          $urandom, 1'($urandom), ab, rs, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_intercon_n.md
WB_INTERCON_N -- requirements
Module: wb_intercon_n

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 26, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-004 SHALL have parameter SEL_LSB, default 16, lowest address bit of the slave-select field; field width SW = clog2(NUM_SLAVES), minimum 1.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for a slave ack (>=1).
REQ-006 SHALL have port clk_i, in, 1: the single clock, all logic on its rising edge.
REQ-007 SHALL have port rst_i, in, 1: reset, synchronous and active-high.
REQ-008 SHALL have master-side inputs m_adr_i (ADDR_WIDTH), m_dat_i (DATA_WIDTH), m_we_i, m_stb_i, m_cyc_i, m_tagn_i (1 each).
REQ-009 SHALL have master-side outputs m_dat_o (DATA_WIDTH), m_ack_o, m_err_o, m_tagn_o (1 each).
REQ-010 SHALL have shared slave outputs s_adr_o (ADDR_WIDTH), s_dat_o (DATA_WIDTH), s_we_o, s_tagn_o (1 each).
REQ-011 SHALL have per-slave outputs s_cyc_o and s_stb_o, NUM_SLAVES bits each, bit i drives slave i.
REQ-012 SHALL have per-slave inputs s_dat_i (NUM_SLAVES*DATA_WIDTH, slave i at [i*DATA_WIDTH +: DATA_WIDTH]), s_ack_i and s_tagn_i (NUM_SLAVES each).
REQ-013 SHALL have status outputs busy_o (1, high whenever not IDLE) and sel_o (SW, latched slave index).

Function
REQ-014 SHALL implement FSM states IDLE, ACTIVE, RESP, ERR, RELEASE.
REQ-015 IDLE: on m_cyc_i & m_stb_i, SHALL latch m_adr_i, m_dat_i, m_we_i, m_tagn_i into s_adr_o/s_dat_o/s_we_o/s_tagn_o and index = m_adr_i[SEL_LSB +: SW] into sel_o.
REQ-016 IDLE: if index < NUM_SLAVES, SHALL go to ACTIVE and set s_cyc_o[index] and s_stb_o[index] on that same edge; otherwise SHALL go to ERR with all strobes low.
REQ-017 ACTIVE: on s_ack_i[sel_o], SHALL capture the s_dat_i slice into m_dat_o and s_tagn_i[sel_o] into m_tagn_o, clear all s_cyc_o/s_stb_o, and go to RESP.
REQ-018 Acks from unselected slaves SHALL be ignored.
REQ-019 RESP: m_ack_o SHALL be high for exactly one cycle, then go to RELEASE.
REQ-020 ERR: m_err_o SHALL be high for exactly one cycle with m_dat_o = 0, then go to RELEASE.
REQ-021 RELEASE: SHALL wait until m_stb_i is low, then go to IDLE; back-to-back requests SHALL therefore require one deasserted strobe cycle.
REQ-022 Latency: request sampled at edge k; strobes high from cycle k+1; an ack in cycle k+1 SHALL give m_ack_o in cycle k+2 (2-cycle minimum).
REQ-023 If m_cyc_i drops in ACTIVE, SHALL clear strobes and go to IDLE with no ack or err (abort).
REQ-024 Simultaneous abort and ack SHALL be treated as abort.
REQ-025 m_ack_o and m_err_o SHALL never be high together.

Reset
REQ-026 On rst_i at a clock edge: state IDLE; m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, busy_o, sel_o, timeout counter = 0; m_dat_o, s_dat_o, s_adr_o = 0; m_tagn_o, s_tagn_o = 1.
REQ-027 Reset asserted mid-transfer SHALL drop all strobes at that edge with no ack or err generated.

Configuration
REQ-028 Macro WB_INTERCON_TIMEOUT_EN defined: a counter of width clog2(TIMEOUT+1) SHALL clear on entry to ACTIVE and increment each ACTIVE cycle without ack; when it reaches TIMEOUT without ack, the block SHALL clear strobes and go to ERR.
REQ-029 Ack in the same cycle the counter reaches TIMEOUT SHALL win (go to RESP).
REQ-030 Macro not defined: no counter SHALL be synthesised; ACTIVE waits indefinitely; unmapped-address ERR SHALL remain.

Verification
REQ-031 Read slave 2 (adr 26'h0020010, NUM_SLAVES=4, SEL_LSB=16), slave acks next cycle with 32'hA5A5_0001 -> s_stb_o=4'b0100 for 1 cycle; m_ack_o one cycle later; m_dat_o=32'hA5A5_0001.
REQ-032 Write adr 26'h0010001, data 32'h0000_00C3, m_we_i=1 -> s_stb_o=4'b0010, s_we_o=1, s_dat_o=32'h0000_00C3; ack after 3 wait cycles gives m_ack_o.
REQ-033 NUM_SLAVES=3, adr field = 3 -> no strobe, m_err_o for 1 cycle, m_dat_o=0.
REQ-034 With WB_INTERCON_TIMEOUT_EN, TIMEOUT=8, slave never acks -> strobe high for exactly 8 cycles, then m_err_o for 1 cycle; ack on 8th cycle -> m_ack_o instead.
REQ-035 rst_i high during ACTIVE; m_cyc_i dropped during ACTIVE -> strobes low next edge, no m_ack_o or m_err_o, busy_o=0.
